// File: rtl/vending_fsm_param.sv
// Two-coin vending controller: accumulates credit, dispenses at PRICE, pays change/refunds in CHANGE_UNIT pulses.
// Optional build macro VEND_SALES_COUNT_EN adds a 16-bit wrapping sales counter output.
module vending_fsm_param #(
  parameter int PRICE       = 15,
  parameter int COIN_LO     = 5,
  parameter int COIN_HI     = 10,
  parameter int CHANGE_UNIT = 5,
  parameter int COIN_W      = 5,
  parameter int CREDIT_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin,
  input  logic                cancel,
  output logic                dispense,
  output logic                change,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                reject
`ifdef VEND_SALES_COUNT_EN
  , output logic [15:0]       sales_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, COLLECT, VEND, PAYOUT, REFUND} state_t;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);
  localparam logic [COIN_W-1:0]   LO_C    = COIN_W'(COIN_LO);
  localparam logic [COIN_W-1:0]   HI_C    = COIN_W'(COIN_HI);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_d, change_amt_d;
  logic [CREDIT_W-1:0] sum, vend_rem, unit_rem;
  logic                coin_ok, reject_d, dispense_d, change_d, busy_d;

  assign coin_ok  = coin_valid && ((coin == LO_C) || (coin == HI_C));
  assign sum      = credit + CREDIT_W'(coin);
  assign vend_rem = credit - PRICE_C;
  assign unit_rem = credit - UNIT_C;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state plus next credit/change_amt/reject; any presented coin is rejected unless credited below.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit;
    change_amt_d = change_amt;
    reject_d     = coin_valid;
    case (state_q)
      IDLE, COLLECT: begin
        if (state_q == COLLECT && cancel) begin
          state_d      = REFUND;
          change_amt_d = credit;
        end else if (coin_ok) begin
          reject_d = 1'b0;
          credit_d = sum;
          if (sum >= PRICE_C) begin
            state_d      = VEND;
            change_amt_d = sum - PRICE_C;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      VEND: begin
        credit_d     = vend_rem;
        change_amt_d = vend_rem;
        state_d      = (vend_rem == '0) ? IDLE : PAYOUT;
      end
      PAYOUT, REFUND: begin
        credit_d = unit_rem;
        if (unit_rem == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    dispense_d = (state_d == VEND);
    change_d   = (state_d == PAYOUT) || (state_d == REFUND);
    busy_d     = (state_d == VEND) || (state_d == PAYOUT) || (state_d == REFUND);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dispense   <= 1'b0;
      change     <= 1'b0;
      busy       <= 1'b0;
      reject     <= 1'b0;
      credit     <= '0;
      change_amt <= '0;
    end else begin
      dispense   <= dispense_d;
      change     <= change_d;
      busy       <= busy_d;
      reject     <= reject_d;
      credit     <= credit_d;
      change_amt <= change_amt_d;
    end
  end

`ifdef VEND_SALES_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                 sales_cnt <= '0;
    else if (state_q == VEND) sales_cnt <= sales_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed bench for vending_fsm_param with default parameters (PRICE 15, coins 5/10, unit 5).
module tb_vending_fsm_param;
  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [4:0] coin;
  logic       cancel;
  logic       dispense, change, busy, reject;
  logic [5:0] change_amt, credit;
`ifdef VEND_SALES_COUNT_EN
  logic [15:0] sales_cnt;
`endif
  int total = 0;
  int bad   = 0;

  vending_fsm_param dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
    .dispense(dispense), .change(change), .change_amt(change_amt), .credit(credit),
    .busy(busy), .reject(reject)
`ifdef VEND_SALES_COUNT_EN
    , .sales_cnt(sales_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [4:0] c, input logic cn);
    coin_valid = v;
    coin       = c;
    cancel     = cn;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic d, input logic ch, input logic b,
                         input logic rj, input logic [5:0] cr, input logic [5:0] ca);
    chk({tag, ".dispense"},   dispense,   d);
    chk({tag, ".change"},     change,     ch);
    chk({tag, ".busy"},       busy,       b);
    chk({tag, ".reject"},     reject,     rj);
    chk({tag, ".credit"},     credit,     cr);
    chk({tag, ".change_amt"}, change_amt, ca);
  endtask

  initial begin
    rst = 1'b0; coin_valid = 1'b0; coin = '0; cancel = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk_all("reset", 0, 0, 0, 0, 6'd0, 6'd0);
    rst = 1'b1;

    // 5+5+5: exact price, no change
    step(1, 5, 0);  chk_all("c555_a", 0, 0, 0, 0, 6'd5, 6'd0);
    step(1, 5, 0);  chk_all("c555_b", 0, 0, 0, 0, 6'd10, 6'd0);
    step(1, 5, 0);  chk_all("c555_vend", 1, 0, 1, 0, 6'd15, 6'd0);
    step(0, 0, 0);  chk_all("c555_idle", 0, 0, 0, 0, 6'd0, 6'd0);

    // 10+10: vend then one change pulse
    step(1, 10, 0); chk_all("c1010_a", 0, 0, 0, 0, 6'd10, 6'd0);
    step(1, 10, 0); chk_all("c1010_vend", 1, 0, 1, 0, 6'd20, 6'd5);
    step(0, 0, 0);  chk_all("c1010_pay", 0, 1, 1, 0, 6'd5, 6'd5);
    step(0, 0, 0);  chk_all("c1010_idle", 0, 0, 0, 0, 6'd0, 6'd5);

    // 5 then cancel: one refund pulse
    step(1, 5, 0);  chk_all("r5_a", 0, 0, 0, 0, 6'd5, 6'd5);
    step(0, 0, 1);  chk_all("r5_ref", 0, 1, 1, 0, 6'd5, 6'd5);
    step(0, 0, 0);  chk_all("r5_idle", 0, 0, 0, 0, 6'd0, 6'd5);

    // 10 then cancel: two refund pulses of 5
    step(1, 10, 0); chk_all("r10_a", 0, 0, 0, 0, 6'd10, 6'd5);
    step(0, 0, 1);  chk_all("r10_ref1", 0, 1, 1, 0, 6'd10, 6'd10);
    step(0, 0, 0);  chk_all("r10_ref2", 0, 1, 1, 0, 6'd5, 6'd10);
    step(0, 0, 0);  chk_all("r10_idle", 0, 0, 0, 0, 6'd0, 6'd10);

    // invalid coin in IDLE, then coin together with cancel
    step(1, 7, 0);  chk_all("bad7", 0, 0, 0, 1, 6'd0, 6'd10);
    step(1, 5, 0);  chk_all("cx_a", 0, 0, 0, 0, 6'd5, 6'd10);
    step(1, 5, 1);  chk_all("cx_ref", 0, 1, 1, 1, 6'd5, 6'd5);
    step(0, 0, 0);  chk_all("cx_idle", 0, 0, 0, 0, 6'd0, 6'd5);
`ifdef VEND_SALES_COUNT_EN
    chk("sales_cnt", sales_cnt, 32'd2);
`endif

    // cancel in IDLE is ignored
    step(0, 0, 1);  chk_all("idle_cancel", 0, 0, 0, 0, 6'd0, 6'd5);

    // coin during VEND is rejected, then reset mid-PAYOUT
    step(1, 10, 0); chk_all("rs_a", 0, 0, 0, 0, 6'd10, 6'd5);
    step(1, 10, 0); chk_all("rs_vend", 1, 0, 1, 0, 6'd20, 6'd5);
    step(1, 5, 0);  chk_all("rs_pay", 0, 1, 1, 1, 6'd5, 6'd5);
    rst = 1'b0;
    step(0, 0, 0);  chk_all("rs_reset", 0, 0, 0, 0, 6'd0, 6'd0);
`ifdef VEND_SALES_COUNT_EN
    chk("sales_cnt_rst", sales_cnt, 32'd0);
`endif
    rst = 1'b1;
    step(1, 5, 0);  chk_all("post_rst", 0, 0, 0, 0, 6'd5, 6'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
